// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory request per instruction from the core,
// drives a valid/ready data bus with lane enables and replicated write data,
// and returns a sign- or zero-extended load result while stalling the core.
module load_store_unit #(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        access_fault,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUS_ADDR = 2'd1,
        BUS_RESP = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic             TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Byte enables for the access size and byte offset.
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the store data across every lane it could land in.
    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Pick the addressed lane of the read data and extend it.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = d;
        endcase
        return r;
    endfunction

    state_t            state_r;
    logic              we_r;
    logic [2:0]        funct3_r;
    logic [1:0]        off_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              done_r;
    logic              fault_r;
    logic              bus_valid_r;
    logic              bus_we_r;
    logic [31:0]       bus_addr_r;
    logic [3:0]        bus_be_r;
    logic [31:0]       bus_wdata_r;
    logic [31:0]       load_data_r;

    logic legal_s;
    logic mis_s;
    logic req_idle_s;
    logic start_s;
    logic busy_s;
    logic complete_s;
    logic abort_s;

    // Decode which funct3 values are legal for the requested direction.
    always_comb begin
        legal_s = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: legal_s = 1'b1;
            3'b100, 3'b101:         legal_s = ~req_we;
            default:                legal_s = 1'b0;
        endcase
    end

    // Halfwords need an even address, words need a word-aligned address.
    always_comb begin
        mis_s = 1'b0;
        case (req_funct3[1:0])
            2'b01:   mis_s = req_addr[0];
            2'b10:   mis_s = (req_addr[1:0] != 2'b00);
            default: mis_s = 1'b0;
        endcase
    end

    assign req_idle_s = (state_r == IDLE) && req_valid && !rst;
    assign start_s    = req_idle_s && legal_s && !mis_s;
    assign busy_s     = (state_r == BUS_ADDR) || (state_r == BUS_RESP);
    // A response only counts once the address phase has been accepted.
    assign complete_s = ((state_r == BUS_ADDR) && bus_ready && bus_rvalid) ||
                        ((state_r == BUS_RESP) && bus_rvalid);
    assign abort_s    = busy_s && !complete_s && TO_EN && (cnt_r == CNT_LAST);

    // Rejections are reported in the request cycle so the core never stalls on them.
    assign access_fault = (req_idle_s && !legal_s) || fault_r;
    assign misaligned   = req_idle_s && legal_s && mis_s;
    assign stall        = start_s || busy_s;
    assign done         = done_r;
    assign load_data    = load_data_r;
    assign bus_valid    = bus_valid_r;
    assign bus_we       = bus_we_r;
    assign bus_addr     = bus_addr_r;
    assign bus_be       = bus_be_r;
    assign bus_wdata    = bus_wdata_r;

    // Access sequencer: latch request, run the bus handshake, complete or time out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            we_r        <= 1'b0;
            funct3_r    <= 3'd0;
            off_r       <= 2'd0;
            cnt_r       <= '0;
            done_r      <= 1'b0;
            fault_r     <= 1'b0;
            bus_valid_r <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'd0;
            bus_be_r    <= 4'd0;
            bus_wdata_r <= 32'd0;
            load_data_r <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r  <= 1'b0;
                    fault_r <= 1'b0;
                    if (start_s) begin
                        we_r        <= req_we;
                        funct3_r    <= req_funct3;
                        off_r       <= req_addr[1:0];
                        cnt_r       <= '0;
                        bus_valid_r <= 1'b1;
                        bus_we_r    <= req_we;
                        bus_addr_r  <= {req_addr[31:2], 2'b00};
                        bus_be_r    <= lane_be(req_funct3, req_addr[1:0]);
                        bus_wdata_r <= lane_wdata(req_funct3, req_wdata);
                        state_r     <= BUS_ADDR;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUS_ADDR, BUS_RESP: begin
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (complete_s) begin
                        bus_valid_r <= 1'b0;
                        done_r      <= 1'b1;
                        if (!we_r) begin
                            load_data_r <= load_extend(funct3_r, off_r, bus_rdata);
                        end else begin
                            load_data_r <= load_data_r;
                        end
                        state_r <= DONE;
                    end else if (abort_s) begin
                        bus_valid_r <= 1'b0;
                        done_r      <= 1'b1;
                        fault_r     <= 1'b1;
                        load_data_r <= 32'd0;
                        state_r     <= DONE;
                    end else if ((state_r == BUS_ADDR) && bus_ready) begin
                        bus_valid_r <= 1'b0;
                        state_r     <= BUS_RESP;
                    end else begin
                        state_r <= state_r;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    fault_r <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit: a default instance for the
// main access tests and a TIMEOUT=4 instance for the abort path.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid_t, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        bus_ready, bus_ready_t, bus_rvalid;
    logic [31:0] bus_rdata;

    logic        stall, done, misaligned, access_fault, bus_valid, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    logic        stall_t, done_t, misaligned_t, access_fault_t, bus_valid_t, bus_we_t;
    logic [31:0] load_data_t, bus_addr_t, bus_wdata_t;
    logic [3:0]  bus_be_t;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .done(done), .load_data(load_data), .misaligned(misaligned),
        .access_fault(access_fault), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    load_store_unit #(.TIMEOUT(4), .CNT_W(3)) dut_t (
        .clk(clk), .rst(rst), .req_valid(req_valid_t), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall_t), .done(done_t), .load_data(load_data_t), .misaligned(misaligned_t),
        .access_fault(access_fault_t), .bus_valid(bus_valid_t), .bus_ready(bus_ready_t),
        .bus_we(bus_we_t), .bus_addr(bus_addr_t), .bus_be(bus_be_t), .bus_wdata(bus_wdata_t),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
    endtask

    // Load with the address and response phases completing together.
    task automatic load_b2b(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rd, input logic [31:0] exp,
                            input logic [3:0] exp_be);
        int sc;
        sc = 0;
        set_req(1'b0, f3, a, 32'd0);
        req_valid = 1'b1;
        bus_ready = 1'b1;
        #1;
        if (stall) sc++;
        tick();
        req_valid  = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = rd;
        #1;
        if (stall) sc++;
        check_val({tag, "_valid"}, {31'd0, bus_valid}, 32'd1);
        check_val({tag, "_be"}, {28'd0, bus_be}, {28'd0, exp_be});
        check_val({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
        tick();
        bus_ready  = 1'b0;
        bus_rvalid = 1'b0;
        #1;
        if (stall) sc++;
        check_val({tag, "_done"}, {31'd0, done}, 32'd1);
        check_val({tag, "_data"}, load_data, exp);
        check_val({tag, "_stallcyc"}, sc, 32'd2);
        tick();
        #1;
        check_val({tag, "_donepulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        logic seen;
        rst = 1'b1;
        req_valid = 1'b0; req_valid_t = 1'b0;
        set_req(1'b0, 3'd0, 32'd0, 32'd0);
        bus_ready = 1'b0; bus_ready_t = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        #12;
        check_val("rst_stall", {31'd0, stall}, 32'd0);
        check_val("rst_valid", {31'd0, bus_valid}, 32'd0);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_ldata", load_data, 32'd0);
        check_val("rst_be", {28'd0, bus_be}, 32'd0);
        rst = 1'b0;
        tick();

        load_b2b("lw", 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'hF);
        load_b2b("lb", 3'b000, 32'h0000_0203, 32'h8011_2233, 32'hFFFF_FF80, 4'b1000);
        load_b2b("lbu", 3'b100, 32'h0000_0203, 32'h8011_2233, 32'h0000_0080, 4'b1000);
        load_b2b("lhu", 3'b101, 32'h0000_0202, 32'h8011_2233, 32'h0000_8011, 4'b1100);
        load_b2b("lh", 3'b001, 32'h0000_0202, 32'h8011_2233, 32'hFFFF_8011, 4'b1100);
        load_b2b("lhlo", 3'b001, 32'h0000_0200, 32'h8011_2233, 32'h0000_2233, 4'b0011);

        // SB with the address phase held off for three cycles.
        set_req(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5);
        req_valid = 1'b1;
        #1;
        check_val("sb_stall0", {31'd0, stall}, 32'd1);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("sb_valid", {31'd0, bus_valid}, 32'd1);
            check_val("sb_addr", bus_addr, 32'h0000_0100);
            check_val("sb_be", {28'd0, bus_be}, 32'h0000_0002);
            check_val("sb_wdata", bus_wdata, 32'hA5A5_A5A5);
            check_val("sb_we", {31'd0, bus_we}, 32'd1);
            check_val("sb_stall", {31'd0, stall}, 32'd1);
            tick();
        end
        bus_ready = 1'b1;
        tick();
        bus_ready = 1'b0;
        #1;
        check_val("sb_resp_valid", {31'd0, bus_valid}, 32'd0);
        check_val("sb_resp_stall", {31'd0, stall}, 32'd1);
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h1234_5678;
        tick();
        bus_rvalid = 1'b0;
        #1;
        check_val("sb_done", {31'd0, done}, 32'd1);
        check_val("sb_ldata_kept", load_data, 32'h0000_2233);
        check_val("sb_done_stall", {31'd0, stall}, 32'd0);
        tick();

        // SH to the upper half, back-to-back completion.
        set_req(1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD);
        req_valid = 1'b1;
        bus_ready = 1'b1;
        tick();
        req_valid  = 1'b0;
        bus_rvalid = 1'b1;
        #1;
        check_val("sh_be", {28'd0, bus_be}, 32'h0000_000C);
        check_val("sh_wdata", bus_wdata, 32'hABCD_ABCD);
        tick();
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        #1;
        check_val("sh_done", {31'd0, done}, 32'd1);
        tick();

        // Misaligned word load.
        set_req(1'b0, 3'b010, 32'h0000_0102, 32'd0);
        req_valid = 1'b1;
        #1;
        check_val("mis_pulse", {31'd0, misaligned}, 32'd1);
        check_val("mis_stall", {31'd0, stall}, 32'd0);
        check_val("mis_fault", {31'd0, access_fault}, 32'd0);
        tick();
        req_valid = 1'b0;
        #1;
        check_val("mis_novalid", {31'd0, bus_valid}, 32'd0);
        check_val("mis_clear", {31'd0, misaligned}, 32'd0);

        // Illegal funct3 beats misalignment.
        set_req(1'b0, 3'b011, 32'h0000_0101, 32'd0);
        req_valid = 1'b1;
        #1;
        check_val("ill_fault", {31'd0, access_fault}, 32'd1);
        check_val("ill_mis", {31'd0, misaligned}, 32'd0);
        check_val("ill_stall", {31'd0, stall}, 32'd0);
        tick();
        req_valid = 1'b0;
        #1;
        check_val("ill_novalid", {31'd0, bus_valid}, 32'd0);
        check_val("ill_clear", {31'd0, access_fault}, 32'd0);
        set_req(1'b1, 3'b100, 32'h0000_0100, 32'd0);
        req_valid = 1'b1;
        #1;
        check_val("ill_store", {31'd0, access_fault}, 32'd1);
        tick();
        req_valid = 1'b0;

        // Timeout instance: a normal load first so the abort visibly clears load_data.
        set_req(1'b0, 3'b010, 32'h0000_0100, 32'd0);
        req_valid_t = 1'b1;
        bus_ready_t = 1'b1;
        tick();
        req_valid_t = 1'b0;
        bus_rvalid  = 1'b1;
        bus_rdata   = 32'h5555_AAAA;
        tick();
        bus_rvalid  = 1'b0;
        bus_ready_t = 1'b0;
        #1;
        check_val("to_pre_data", load_data_t, 32'h5555_AAAA);
        check_val("idle_rvalid_ignored", {31'd0, done}, 32'd0);
        tick();
        req_valid_t = 1'b1;
        tick();
        req_valid_t = 1'b0;
        vcnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (done_t) begin
                seen = 1'b1;
                check_val("to_fault", {31'd0, access_fault_t}, 32'd1);
                check_val("to_data", load_data_t, 32'd0);
                check_val("to_valid", {31'd0, bus_valid_t}, 32'd0);
            end else begin
                if (bus_valid_t) vcnt++;
                tick();
            end
        end
        check_val("to_seen", {31'd0, seen}, 32'd1);
        check_val("to_vcycles", vcnt, 32'd4);
        tick();
        #1;
        check_val("to_done_pulse", {31'd0, done_t}, 32'd0);
        check_val("to_fault_pulse", {31'd0, access_fault_t}, 32'd0);

        // Reset in the middle of the response phase.
        set_req(1'b0, 3'b010, 32'h0000_0300, 32'd0);
        req_valid = 1'b1;
        bus_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        bus_ready = 1'b0;
        #1;
        check_val("rr_stall_resp", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("rr_stall", {31'd0, stall}, 32'd0);
        check_val("rr_valid", {31'd0, bus_valid}, 32'd0);
        check_val("rr_ldata", load_data, 32'd0);
        tick();
        rst = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h0000_0BAD;
        tick();
        bus_rvalid = 1'b0;
        #1;
        check_val("rr_late_done", {31'd0, done}, 32'd0);
        check_val("rr_late_stall", {31'd0, stall}, 32'd0);
        tick();
        load_b2b("rr_lw", 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
